// File: rtl/uart_tx.sv
// UART 8N1-style serial transmitter with valid/ready byte input and registered line output.
// Optional parity bit enabled by defining UART_TX_PARITY_EN (even/odd selected by PARITY_ODD).
module uart_tx #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115_200,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int DIV = CLK_FREQ / BAUD;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BW  = $clog2(DATA_BITS + 1);

  localparam logic [CW-1:0] CNT_LAST  = CW'(DIV - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

  if (DIV < 2) begin : g_chk_div
    $error("uart_tx: CLK_FREQ/BAUD must be >= 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_chk_data
    $error("uart_tx: DATA_BITS must be 5..9");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_chk_stop
    $error("uart_tx: STOP_BITS must be 1 or 2");
  end
  if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_chk_par
    $error("uart_tx: PARITY_ODD must be 0 or 1");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_e;

  state_e                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [BW-1:0]          bit_q, bit_d;
  logic [DATA_BITS-1:0]   shreg_q, shreg_d;
  logic                   tx_q, tx_d;
  logic                   ready_q, ready_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   baud_end;
`ifdef UART_TX_PARITY_EN
  logic                   par_q, par_d;
`endif

  assign baud_end = (cnt_q == CNT_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      tx_q    <= 1'b1;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      tx_q    <= tx_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  // bit_q counts data bits in S_DATA and stop bits in S_STOP.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    bit_d   = bit_q;
    shreg_d = shreg_q;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        if (tx_valid && ready_q) begin
          state_d = S_START;
          shreg_d = tx_data;
`ifdef UART_TX_PARITY_EN
          par_d   = (^tx_data) ^ (PARITY_ODD != 0);
`endif
        end
      end
      S_START: begin
        if (baud_end) begin
          state_d = S_DATA;
          cnt_d   = '0;
          bit_d   = '0;
        end
      end
      S_DATA: begin
        if (baud_end) begin
          cnt_d   = '0;
          shreg_d = shreg_q >> 1;
          if (bit_q == DATA_LAST) begin
            bit_d   = '0;
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (baud_end) begin
          state_d = S_STOP;
          cnt_d   = '0;
          bit_d   = '0;
        end
      end
`endif
      S_STOP: begin
        if (baud_end) begin
          cnt_d = '0;
          if (bit_q == STOP_LAST) begin
            state_d = S_IDLE;
            bit_d   = '0;
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        bit_d   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so that they register in step with it.
  always_comb begin
    tx_d    = 1'b1;
    ready_d = 1'b0;
    busy_d  = 1'b1;
    done_d  = 1'b0;
    case (state_d)
      S_IDLE: begin
        ready_d = 1'b1;
        busy_d  = 1'b0;
      end
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shreg_d[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: tx_d = par_q;
`endif
      S_STOP:   done_d = (cnt_d == CNT_LAST) && (bit_d == STOP_LAST);
      default: begin
        ready_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign tx       = tx_q;
  assign tx_ready = ready_q;
  assign tx_busy  = busy_q;
  assign tx_done  = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: driver queues expected frames, a negedge monitor checks the line.
module tb_uart_tx;

  localparam int CLK_FREQ   = 50_000_000;
  localparam int BAUD       = 5_000_000;
  localparam int DIV        = CLK_FREQ / BAUD;
  localparam int DB         = 8;
  localparam int STOP_BITS  = 1;
  localparam int PARITY_ODD = 0;
`ifdef UART_TX_PARITY_EN
  localparam int PAR_BITS   = 1;
`else
  localparam int PAR_BITS   = 0;
`endif
  localparam int FRAME_BITS = 1 + DB + PAR_BITS + STOP_BITS;
  localparam int FRAME_CYC  = FRAME_BITS * DIV;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DB-1:0] tx_data = '0;
  logic          tx_valid = 1'b0;
  logic          tx_ready, tx, tx_busy, tx_done;

  uart_tx #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD      (BAUD),
    .DATA_BITS (DB),
    .STOP_BITS (STOP_BITS),
    .PARITY_ODD(PARITY_ODD)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .tx_data (tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .tx      (tx),
    .tx_busy (tx_busy),
    .tx_done (tx_done)
  );

  always #10 clk = ~clk;

  typedef struct {
    logic [DB-1:0] data;
    int            hs;
  } exp_t;

  exp_t exp_q[$];
  int   starts[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  logic rst_at_edge = 1'b1;

  always @(posedge clk) begin
    cyc         <= cyc + 1;
    rst_at_edge <= !rst_n;
  end

  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Line level of frame bit idx: start 0, data LSB-first, optional parity, stop 1.
  function automatic logic frame_bit(input logic [DB-1:0] d, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= DB) return d[idx-1];
`ifdef UART_TX_PARITY_EN
    if (idx == DB + 1) return (^d) ^ (PARITY_ODD != 0);
`endif
    return 1'b1;
  endfunction

  bit       in_frame = 0;
  int       c = 0;
  exp_t     cur;
  bit       tx_ok, st_ok;
  logic     tx_bad, tx_exp;
  logic [2:0] st_bad, st_exp;

  always @(negedge clk) begin
    if (rst_at_edge) begin
      in_frame = 0;
      exp_q.delete();
    end else begin
      if (!in_frame && tx === 1'b0) begin
        if (exp_q.size() == 0) begin
          chk(1'b0, "unexpected_frame", 32'(cyc), 32'(0));
          cur.data = '0;
          cur.hs   = cyc;
        end else begin
          cur = exp_q.pop_front();
          chk(cur.hs == cyc, "start_latency", 32'(cyc), 32'(cur.hs));
        end
        starts.push_back(cyc);
        in_frame = 1;
        c = 0;
      end else if (in_frame && c == FRAME_CYC) begin
        chk(tx === 1'b1 && tx_ready === 1'b1 && tx_busy === 1'b0 && tx_done === 1'b0,
            "idle_after_frame", {28'd0, tx, tx_ready, tx_busy, tx_done}, 32'hC);
        in_frame = 0;
      end
      if (in_frame && c < FRAME_CYC) begin
        if (c % DIV == 0) begin
          tx_ok = 1;
          st_ok = 1;
          tx_exp = frame_bit(cur.data, c / DIV);
        end
        if (tx !== tx_exp && tx_ok) begin
          tx_ok  = 0;
          tx_bad = tx;
        end
        if ({tx_busy, tx_ready, tx_done} !== {2'b10, 1'(c == FRAME_CYC - 1)} && st_ok) begin
          st_ok  = 0;
          st_bad = {tx_busy, tx_ready, tx_done};
          st_exp = {2'b10, 1'(c == FRAME_CYC - 1)};
        end
        if (c % DIV == DIV - 1) begin
          chk(tx_ok, $sformatf("bit%0d_of_%02h", c / DIV, cur.data), 32'(tx_bad), 32'(tx_exp));
          chk(st_ok, $sformatf("busy_ready_done_bit%0d_of_%02h", c / DIV, cur.data),
              32'(st_bad), 32'(st_exp));
        end
        c++;
      end
    end
  end

  // Called at a negedge; returns at the negedge after the handshake edge, with tx_data disturbed.
  task automatic send(input logic [DB-1:0] d, input bit keep);
    int t;
    exp_t e;
    tx_data  = d;
    tx_valid = 1'b1;
    t = 0;
    while (tx_ready !== 1'b1 && t < 3 * FRAME_CYC) begin
      @(negedge clk);
      t++;
    end
    if (tx_ready !== 1'b1) begin
      chk(1'b0, "send_ready_timeout", 32'(t), 32'(3 * FRAME_CYC));
      tx_valid = 1'b0;
      return;
    end
    e.data = d;
    e.hs   = cyc + 1;
    exp_q.push_back(e);
    @(negedge clk);
    tx_data = ~d;
    if (!keep) tx_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (!(exp_q.size() == 0 && !in_frame && tx_ready === 1'b1) && t < 4 * FRAME_CYC) begin
      @(negedge clk);
      t++;
    end
    if (t >= 4 * FRAME_CYC) chk(1'b0, "idle_timeout", 32'(t), 32'(4 * FRAME_CYC));
    @(negedge clk);
  endtask

  initial begin
    bit keep, keep_prev;

    // Reset with tx_valid held high: nothing may start.
    tx_valid = 1'b1;
    tx_data  = 8'hA5;
    rst_n    = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk({tx, tx_ready, tx_busy, tx_done} === 4'b1000, $sformatf("reset_outputs_%0d", i),
          {28'd0, tx, tx_ready, tx_busy, tx_done}, 32'h8);
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk(tx_ready === 1'b1, "ready_after_release", 32'(tx_ready), 32'(1));
    send(8'hA5, 1'b0);
    wait_idle();

    // Back-to-back with tx_valid held.
    starts.delete();
    send(8'h00, 1'b1);
    send(8'hFF, 1'b0);
    wait_idle();
    chk(starts.size() == 2, "b2b_frame_count", 32'(starts.size()), 32'(2));
    if (starts.size() == 2)
      chk(starts[1] - starts[0] == FRAME_CYC + 1, "b2b_start_spacing",
          32'(starts[1] - starts[0]), 32'(FRAME_CYC + 1));

    // tx_data flips to 8'hC3 one clk after handshake.
    send(8'h3C, 1'b0);
    wait_idle();

    // Parity-relevant patterns.
    send(8'h07, 1'b0);
    send(8'h03, 1'b0);
    wait_idle();

    // Random bytes, gaps and back-to-back runs.
    keep_prev = 0;
    for (int i = 0; i < 20; i++) begin
      if (!keep_prev) repeat ($urandom_range(0, 4)) @(negedge clk);
      keep = (i == 19) ? 1'b0 : 1'($urandom_range(0, 1));
      send(8'($urandom), keep);
      keep_prev = keep;
    end
    wait_idle();

    // Reset during data bit 3, then a clean frame.
    send(8'h0F, 1'b0);
    repeat (43) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk({tx, tx_ready, tx_busy, tx_done} === 4'b1000, "midframe_reset_outputs",
        {28'd0, tx, tx_ready, tx_busy, tx_done}, 32'h8);
    @(negedge clk);
    chk(tx === 1'b1, "midframe_reset_tx_high", 32'(tx), 32'(1));
    rst_n = 1'b1;
    @(negedge clk);
    chk(tx_ready === 1'b1, "ready_after_midframe_release", 32'(tx_ready), 32'(1));
    send(8'h55, 1'b0);
    wait_idle();

    chk(exp_q.size() == 0, "scoreboard_drained", 32'(exp_q.size()), 32'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
